// File: rtl/dllp_acknak_rx.sv
// ACK/NAK DLLP receiver: frames 3-word DLLPs, checks CRC-16, reports ACK/NAK
// with sequence number, counts discarded DLLPs and runs the replay timer.
module dllp_acknak_rx #(
    parameter logic [15:0] REPLAY_LIMIT = 16'd711,
    parameter int          ERR_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dllp_valid,
    input  logic             dllp_sop,
    input  logic [15:0]      din,
    input  logic             tx_pending,
    output logic [1:0]       ack_nack,
    output logic [11:0]      seq,
    output logic             tim_out,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [15:0] CRC_POLY = 16'h100B;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [7:0]  TYPE_ACK = 8'h00;
    localparam logic [7:0]  TYPE_NAK = 8'h10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GOT0 = 2'd1,
        S_GOT1 = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_crc, w_crc_nxt;
    logic [7:0]  r_type, w_type_nxt;
    logic [11:0] r_seq_buf, w_seq_buf_nxt;
    logic [15:0] r_timer;
    logic        w_accept;
    logic        w_err_inc;
    logic        w_expire;
    logic [1:0]  w_code;

    // Advances a running CRC by one 16-bit word, MSB first.
    function automatic logic [15:0] crc_word(input logic [15:0] crc_in,
                                             input logic [15:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt   = r_state;
        w_crc_nxt     = r_crc;
        w_type_nxt    = r_type;
        w_seq_buf_nxt = r_seq_buf;
        w_accept      = 1'b0;
        w_err_inc     = 1'b0;
        if (dllp_valid) begin
            if (dllp_sop) begin
                // A new start always wins; anything in flight is discarded as an error.
                w_err_inc   = (r_state != S_IDLE);
                w_state_nxt = S_GOT0;
                w_type_nxt  = din[15:8];
                w_crc_nxt   = crc_word(CRC_INIT, din);
            end else begin
                case (r_state)
                    S_GOT0: begin
                        w_seq_buf_nxt = din[11:0];
                        w_crc_nxt     = crc_word(r_crc, din);
                        w_state_nxt   = S_GOT1;
                    end
                    S_GOT1: begin
                        w_state_nxt = S_IDLE;
                        w_crc_nxt   = CRC_INIT;
                        if (din == ~r_crc)
                            w_accept = (r_type == TYPE_ACK) || (r_type == TYPE_NAK);
                        else
                            w_err_inc = 1'b1;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    assign w_code   = (r_type == TYPE_ACK) ? 2'b01 : 2'b10;
    assign w_expire = tx_pending && (r_timer == REPLAY_LIMIT - 16'd1);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_crc     <= CRC_INIT;
            r_type    <= 8'h00;
            r_seq_buf <= 12'h000;
        end else begin
            r_state   <= w_state_nxt;
            r_crc     <= w_crc_nxt;
            r_type    <= w_type_nxt;
            r_seq_buf <= w_seq_buf_nxt;
        end
    end

    // An accepted ACK/NAK restarts the timer and masks a coincident expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_nack <= 2'b00;
            seq      <= 12'h000;
            tim_out  <= 1'b0;
            r_timer  <= 16'h0000;
            err_cnt  <= '0;
        end else begin
            ack_nack <= w_accept ? w_code : 2'b00;
            if (w_accept) seq <= r_seq_buf;
            tim_out  <= w_expire && !w_accept;
            if (!tx_pending || w_accept || w_expire) r_timer <= 16'h0000;
            else                                     r_timer <= r_timer + 16'd1;
            if (w_err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dllp_acknak_rx.sv
// Self-checking bench for dllp_acknak_rx: directed scenarios plus randomized
// traffic compared each cycle against a word-queue reference model.
module tb_dllp_acknak_rx;

    localparam int LIM   = 8;
    localparam int EW    = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          dllp_valid;
    logic          dllp_sop;
    logic [15:0]   din;
    logic          tx_pending;
    logic [1:0]    ack_nack;
    logic [11:0]   seq;
    logic          tim_out;
    logic [EW-1:0] err_cnt;

    dllp_acknak_rx #(.REPLAY_LIMIT(16'(LIM)), .ERR_W(EW)) dut (
        .clk(clk), .reset_n(reset_n), .dllp_valid(dllp_valid), .dllp_sop(dllp_sop),
        .din(din), .tx_pending(tx_pending), .ack_nack(ack_nack), .seq(seq),
        .tim_out(tim_out), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the partial DLLP is simply the list of words seen since sop.
    logic [15:0] m_words[$];
    int          m_timer;
    logic [1:0]  m_ack;
    logic [11:0] m_seq;
    logic        m_tim;
    int          m_err;

    function automatic logic [15:0] ref_crc(input logic [31:0] msg);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ msg[i]) c = (c << 1) ^ 16'h100B;
            else                c = c << 1;
        end
        return c;
    endfunction

    function automatic logic [15:0] good_w2(input logic [15:0] w0, input logic [15:0] w1);
        return ~ref_crc({w0, w1});
    endfunction

    task automatic model_reset();
        m_words.delete();
        m_timer = 0;
        m_ack   = 2'b00;
        m_seq   = 12'h000;
        m_tim   = 1'b0;
        m_err   = 0;
    endtask

    task automatic model_edge();
        bit         acc;
        bit         bad;
        logic [1:0] code;
        acc  = 0;
        bad  = 0;
        code = 2'b00;
        if (dllp_valid) begin
            if (dllp_sop) begin
                if (m_words.size() != 0) bad = 1;
                m_words.delete();
                m_words.push_back(din);
            end else if (m_words.size() != 0) begin
                m_words.push_back(din);
                if (m_words.size() == 3) begin
                    if (m_words[2] == good_w2(m_words[0], m_words[1])) begin
                        if (m_words[0][15:8] == 8'h00) begin acc = 1; code = 2'b01; end
                        if (m_words[0][15:8] == 8'h10) begin acc = 1; code = 2'b10; end
                        if (acc) m_seq = m_words[1][11:0];
                    end else begin
                        bad = 1;
                    end
                    m_words.delete();
                end
            end
        end
        m_ack = code;
        m_tim = 1'b0;
        if (!tx_pending || acc) m_timer = 0;
        else if (m_timer == LIM - 1) begin m_timer = 0; m_tim = 1'b1; end
        else m_timer++;
        if (bad && m_err < ERR_MAX) m_err++;
    endtask

    task automatic step(input logic v, input logic s, input logic [15:0] d, input logic txp);
        dllp_valid = v;
        dllp_sop   = s;
        din        = d;
        tx_pending = txp;
        @(posedge clk);
        model_edge();
        #1;
        check("ack_nack", 32'(ack_nack), 32'(m_ack));
        check("seq", 32'(seq), 32'(m_seq));
        check("tim_out", 32'(tim_out), 32'(m_tim));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic idle(input logic txp);
        step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), txp);
    endtask

    task automatic emit(input logic s, input logic [15:0] d, input logic txp);
        while ($urandom_range(0, 3) == 0) idle(txp);
        step(1'b1, s, d, txp);
    endtask

    task automatic send_dllp(input logic [7:0] typ, input logic [11:0] sq,
                             input bit corrupt, input logic txp);
        logic [15:0] w0, w1, w2;
        w0 = {typ, 8'h00};
        w1 = {4'h0, sq};
        w2 = good_w2(w0, w1);
        if (corrupt) w2 = w2 ^ (16'h1 << $urandom_range(0, 15));
        emit(1'b1, w0, txp);
        emit(1'b0, w1, txp);
        emit(1'b0, w2, txp);
    endtask

    int          e0;
    logic        txp;
    logic [15:0] w;

    initial begin
        reset_n    = 1'b1;
        dllp_valid = 1'b0;
        dllp_sop   = 1'b0;
        din        = 16'h0000;
        tx_pending = 1'b0;
        #2 reset_n = 1'b0;
        #20;
        check("rst_ack", 32'(ack_nack), 32'h0);
        check("rst_seq", 32'(seq), 32'h0);
        check("rst_tim", 32'(tim_out), 32'h0);
        check("rst_err", 32'(err_cnt), 32'h0);
        model_reset();
        @(negedge clk) reset_n = 1'b1;

        // Good ACK, reported one cycle after W2 for one cycle only.
        step(1, 1, 16'h0000, 0);
        step(1, 0, 16'h0123, 0);
        step(1, 0, good_w2(16'h0000, 16'h0123), 0);
        check("ack_pulse", 32'(ack_nack), 32'h1);
        check("ack_seq", 32'(seq), 32'h123);
        step(0, 0, 16'h0000, 0);
        check("ack_drop", 32'(ack_nack), 32'h0);
        check("ack_seq_hold", 32'(seq), 32'h123);

        // Good NAK with a two-cycle valid gap before W2.
        e0 = m_err;
        step(1, 1, 16'h1000, 0);
        step(1, 0, 16'h0ABC, 0);
        step(0, 1, 16'hFFFF, 0);
        step(0, 0, 16'h1234, 0);
        check("nak_gap_quiet", 32'(ack_nack), 32'h0);
        step(1, 0, good_w2(16'h1000, 16'h0ABC), 0);
        check("nak_pulse", 32'(ack_nack), 32'h2);
        check("nak_seq", 32'(seq), 32'hABC);
        check("nak_no_err", 32'(err_cnt), 32'(e0));

        // Corrupted W2 is dropped and counted.
        step(1, 1, 16'h0000, 0);
        step(1, 0, 16'h0555, 0);
        step(1, 0, good_w2(16'h0000, 16'h0555) ^ 16'h0010, 0);
        check("bad_crc_ack", 32'(ack_nack), 32'h0);
        check("bad_crc_seq", 32'(seq), 32'hABC);
        check("bad_crc_err", 32'(err_cnt), 32'(e0 + 1));

        // Unknown type with good CRC: silently discarded.
        step(1, 1, 16'h2200, 0);
        step(1, 0, 16'h0999, 0);
        step(1, 0, good_w2(16'h2200, 16'h0999), 0);
        check("other_type_ack", 32'(ack_nack), 32'h0);
        check("other_type_err", 32'(err_cnt), 32'(e0 + 1));

        // sop while waiting for W2 aborts, then the new DLLP completes.
        step(1, 1, 16'h0000, 0);
        step(1, 0, 16'h0777, 0);
        step(1, 1, 16'h1000, 0);
        check("abort_err", 32'(err_cnt), 32'(e0 + 2));
        step(1, 0, 16'h0321, 0);
        step(1, 0, good_w2(16'h1000, 16'h0321), 0);
        check("abort_new_ack", 32'(ack_nack), 32'h2);
        check("abort_new_seq", 32'(seq), 32'h321);

        // Replay timer expiries at 8, 16, 24 cycles after tx_pending rises.
        step(0, 0, 16'h0000, 0);
        for (int i = 1; i <= 24; i++) begin
            step(0, 0, 16'h0000, 1);
            check($sformatf("timer_c%0d", i), 32'(tim_out), 32'((i % 8) == 0));
        end
        step(0, 0, 16'h0000, 0);

        // ACK landing on the expiry cycle suppresses the pulse and restarts the count.
        for (int i = 1; i <= 5; i++) step(0, 0, 16'h0000, 1);
        step(1, 1, 16'h0000, 1);
        step(1, 0, 16'h0042, 1);
        step(1, 0, good_w2(16'h0000, 16'h0042), 1);
        check("exp_ack", 32'(ack_nack), 32'h1);
        check("exp_suppressed", 32'(tim_out), 32'h0);
        for (int i = 9; i <= 16; i++) step(0, 0, 16'h0000, 1);
        check("exp_restart_pulse", 32'(tim_out), 32'h1);
        step(0, 0, 16'h0000, 0);

        // Reset in the middle of a DLLP; trailing words without sop are ignored.
        step(1, 1, 16'h0000, 1);
        step(1, 0, 16'h0456, 1);
        reset_n = 1'b0;
        #2;
        check("mid_rst_ack", 32'(ack_nack), 32'h0);
        check("mid_rst_seq", 32'(seq), 32'h0);
        check("mid_rst_tim", 32'(tim_out), 32'h0);
        check("mid_rst_err", 32'(err_cnt), 32'h0);
        model_reset();
        dllp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step(1, 0, 16'h0456, 0);
        step(1, 0, good_w2(16'h0000, 16'h0456), 0);
        check("post_rst_ignored", 32'(ack_nack), 32'h0);
        check("post_rst_seq", 32'(seq), 32'h0);
        send_dllp(8'h00, 12'h9A5, 0, 0);
        check("post_rst_good", 32'(ack_nack), 32'h1);

        // Randomized traffic against the model.
        txp = 1'b0;
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) txp = ~txp;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_dllp($urandom_range(0, 1) ? 8'h10 : 8'h00, 12'($urandom), 0, txp);
                4:          send_dllp($urandom_range(0, 1) ? 8'h10 : 8'h00, 12'($urandom), 1, txp);
                5:          send_dllp(8'($urandom_range(1, 255)) | 8'h01, 12'($urandom), 0, txp);
                6: begin
                    emit(1'b1, {($urandom_range(0, 1) ? 8'h10 : 8'h00), 8'h00}, txp);
                    if ($urandom_range(0, 1) == 1) emit(1'b0, 16'($urandom), txp);
                end
                7:          emit(1'b0, 16'($urandom), txp);
                8:          repeat ($urandom_range(1, 12)) idle(txp);
                default: begin
                    w = 16'($urandom);
                    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, txp);
                end
            endcase
        end

        // Error counter saturates instead of wrapping.
        repeat (ERR_MAX + 10) step(1, 1, 16'h0000, 0);
        check("err_saturated", 32'(err_cnt), 32'(ERR_MAX));
        step(0, 0, 16'h0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dllp_acknak_rx.md
DLLP_ACKNAK_RX -- requirements
Module: dllp_acknak_rx

Interface
REQ-001 SHALL have parameter REPLAY_LIMIT, default 16'd711, replay-timer expiry count in clk cycles.
REQ-002 SHALL have parameter ERR_W, default 8, width of the bad-DLLP counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port dllp_valid  input  1  din carries a DLLP word this cycle.
REQ-006 SHALL have port dllp_sop  input  1  first word of a DLLP; qualified by dllp_valid.
REQ-007 SHALL have port din  input  16  DLLP word.
REQ-008 SHALL have port tx_pending  input  1  replay buffer holds unacknowledged TLPs (level).
REQ-009 SHALL have port ack_nack  output  2  00 none, 01 ACK, 10 NAK; 11 never driven.
REQ-010 SHALL have port seq  output  12  sequence number of the last accepted ACK/NAK.
REQ-011 SHALL have port tim_out  output  1  one-cycle replay-timer expiry pulse.
REQ-012 SHALL have port err_cnt  output  ERR_W  saturating count of discarded DLLPs.

Function
REQ-013 SHALL define the DLLP as 3 words: W0={type[7:0],8'h00}, W1={4'h0,seq[11:0]}, W2=crc[15:0].
REQ-014 SHALL treat type 8'h00 as ACK and 8'h10 as NAK; any other type SHALL be discarded without error count.
REQ-015 SHALL run the FSM IDLE -> GOT0 -> GOT1 -> IDLE, advancing only on dllp_valid=1; dllp_valid=0 holds state (stall, no timeout).
REQ-016 SHALL move IDLE->GOT0 only on dllp_valid&dllp_sop; valid words without sop in IDLE are dropped.
REQ-017 SHALL, on dllp_valid&dllp_sop in GOT0 or GOT1, abort the partial DLLP, increment err_cnt, and capture din as a new W0 (stay/enter GOT0).
REQ-018 SHALL compute CRC-16 poly 16'h100B, init 16'hFFFF, over the 32 bits {W0,W1} MSB first; the DLLP is good when W2 == ~crc.
REQ-019 SHALL, when W2 is accepted in GOT1 with good CRC and ACK/NAK type, drive ack_nack to the type code and seq to W1[11:0] on the next cycle (latency 1 cycle after W2).
REQ-020 SHALL hold ack_nack for exactly one cycle then return to 00; seq SHALL hold its value until the next accepted ACK/NAK.
REQ-021 SHALL, on bad CRC, drop the DLLP, leave ack_nack/seq unchanged, and increment err_cnt.
REQ-022 SHALL saturate err_cnt at all-ones (no wrap).
REQ-023 SHALL run a 16-bit replay timer: clears to 0 while tx_pending=0, else increments by 1 per cycle.
REQ-024 SHALL clear the timer to 0 in the cycle ack_nack is non-zero.
REQ-025 SHALL, when the timer equals REPLAY_LIMIT-1 and tx_pending=1, pulse tim_out for one cycle and reload the timer to 0.
REQ-026 SHALL give an accepted ACK/NAK priority over expiry: same cycle -> ack_nack driven, tim_out stays 0, timer 0.
REQ-027 SHALL register all outputs; no combinational input-to-output path.

Reset
REQ-028 SHALL, while reset_n=0, force FSM to IDLE, ack_nack=2'b00, seq=12'h000, tim_out=0, err_cnt=0, timer=0, CRC state=16'hFFFF.
REQ-029 SHALL discard any partial DLLP on reset; the first DLLP after release SHALL require dllp_sop.

Verification
REQ-030 SHALL verify good ACK: W0=16'h0000 (sop), W1=16'h0123, W2=correct CRC -> ack_nack=01 for one cycle after W2, seq=12'h123.
REQ-031 SHALL verify good NAK with a 2-cycle valid gap between W1 and W2 -> ack_nack=10 one cycle after W2, seq updated, no error.
REQ-032 SHALL verify corrupted W2 (one bit flipped) -> ack_nack stays 00, seq unchanged, err_cnt +1.
REQ-033 SHALL verify sop during GOT1 -> err_cnt +1, the new DLLP completes normally and is reported.
REQ-034 SHALL verify tx_pending=1 held with no DLLPs, REPLAY_LIMIT=8 -> tim_out pulses at cycles 8, 16, 24 after tx_pending rise; ACK in the expiry cycle suppresses the pulse.
REQ-035 SHALL verify reset_n asserted mid-DLLP -> all outputs to reset values; a W1/W2 without sop after release is ignored.
